tile_seq_ctrl: RTL

- FSM sequencer that produces the 34-bit `inst` word for one compute core.
- Runs one tile per `start`:
  - fill L0 with `row` weight vectors from xmem, then load them into the array;
  - fill L0 with `num_act` activation vectors, then execute them;
  - drain `num_act` ofifo outputs into psum SRAM, optionally accumulating.
- Sits between the host/testbench and the core. It replaces hand-written instruction streams.

---
 rtl/tile_seq_ctrl.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/tile_seq_ctrl.sv
// tile_seq_ctrl: per-tile instruction sequencer (weight fill/load, activation fill/execute, psum drain)
// Ports: clk, reset (sync, active-high), start, w_base/x_base/p_base, num_act, acc_en,
//   l0_full, ofifo_valid -> inst[33:0], busy, done, err; stall_cnt[15:0] with TILE_SEQ_PERF_EN.
// inst layout: 33 acc | 32 CEN_pmem | 31 WEN_pmem | 30:20 A_pmem | 19 CEN_xmem | 18 WEN_xmem |
//   17:7 A_xmem | 6 ofifo_rd | 5:4 zero | 3 l0_rd | 2 l0_wr | 1 execute | 0 load.
// All input decisions are taken at the clock edge that registers the instruction they affect.
module tile_seq_ctrl #(
  parameter int row = 8,
  parameter int col = 8,
  parameter int l0_depth = 64,
  parameter int addr_bw = 11
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic [addr_bw-1:0] w_base,
  input  logic [addr_bw-1:0] x_base,
  input  logic [addr_bw-1:0] p_base,
  input  logic [6:0] num_act,
  input  logic acc_en,
  input  logic l0_full,
  input  logic ofifo_valid,
  output logic [33:0] inst,
  output logic busy,
  output logic done,
  output logic err
`ifdef TILE_SEQ_PERF_EN
  ,
  output logic [15:0] stall_cnt
`endif
);
  typedef enum logic [2:0] {IDLE, W_FILL, W_LOAD, W_SETTLE, X_FILL, X_EXEC, DRAIN, FIN} state_t;
  localparam logic [33:0] idle_inst = 34'h1_800c_0000;
  localparam logic [7:0] row_c = 8'(row);
  localparam logic [7:0] col_c = 8'(col);
  localparam logic [7:0] l0_c = 8'(l0_depth);
  state_t state;
  logic [addr_bw-1:0] wb, xb, pb;
  logic [7:0] na, rd, wr, cnt;
  logic acc, pend;
  logic [7:0] fill_tgt;
  logic [addr_bw-1:0] fill_base;
  logic fill_wr, fill_rd, drain_rd, na_nz, bad_num;
  assign busy = state != IDLE;
  assign na_nz = na != 8'd0;
  assign bad_num = {1'b0, num_act} > l0_c;
  assign fill_tgt = state == W_FILL ? row_c : na;
  assign fill_base = state == W_FILL ? wb : xb;
  // a pending vector drains into L0 once it has room; a new read may overlap that write
  assign fill_wr = pend & ~l0_full;
  assign fill_rd = (~pend | fill_wr) & (rd < fill_tgt);
  assign drain_rd = ofifo_valid & (rd < na);
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      inst <= idle_inst;
      done <= 1'b0;
      err <= 1'b0;
      wb <= '0;
      xb <= '0;
      pb <= '0;
      na <= '0;
      rd <= '0;
      wr <= '0;
      cnt <= '0;
      acc <= 1'b0;
      pend <= 1'b0;
    end else begin
      inst <= idle_inst;
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          if (bad_num) err <= 1'b1;
          else begin
            wb <= w_base;
            xb <= x_base;
            pb <= p_base;
            na <= {1'b0, num_act};
            acc <= acc_en;
            state <= W_FILL;
            rd <= 8'd1;
            wr <= '0;
            pend <= 1'b1;
            inst[19] <= 1'b0;
            inst[7 +: addr_bw] <= w_base;
          end
        end
        W_FILL, X_FILL: if (wr == fill_tgt) begin
          cnt <= state == W_FILL ? 8'd1 : {7'd0, na_nz};
          inst[0] <= state == W_FILL;
          inst[1] <= state == X_FILL && na_nz;
          inst[3] <= state == W_FILL || na_nz;
          state <= state == W_FILL ? W_LOAD : X_EXEC;
        end else begin
          if (fill_wr) begin
            inst[2] <= 1'b1;
            wr <= wr + 8'd1;
          end
          if (fill_rd) begin
            inst[19] <= 1'b0;
            inst[7 +: addr_bw] <= fill_base + addr_bw'(rd);
            rd <= rd + 8'd1;
          end
          pend <= fill_rd | (pend & ~fill_wr);
        end
        W_LOAD: if (cnt < row_c) begin
          inst[0] <= 1'b1;
          inst[3] <= 1'b1;
          cnt <= cnt + 8'd1;
        end else begin
          state <= W_SETTLE;
          cnt <= 8'd1;
        end
        W_SETTLE: if (cnt < col_c) cnt <= cnt + 8'd1;
        else begin
          state <= X_FILL;
          rd <= {7'd0, na_nz};
          wr <= '0;
          pend <= na_nz;
          inst[19] <= ~na_nz;
          inst[7 +: addr_bw] <= na_nz ? xb : '0;
        end
        X_EXEC: if (cnt < na) begin
          inst[1] <= 1'b1;
          inst[3] <= 1'b1;
          cnt <= cnt + 8'd1;
        end else begin
          state <= DRAIN;
          rd <= {7'd0, ofifo_valid & na_nz};
          wr <= '0;
          pend <= ofifo_valid & na_nz;
          inst[6] <= ofifo_valid & na_nz;
        end
        DRAIN: if (wr == na) begin
          state <= FIN;
          done <= 1'b1;
        end else begin
          if (pend) begin
            inst[33] <= acc;
            inst[32] <= 1'b0;
            inst[31] <= 1'b0;
            inst[20 +: addr_bw] <= pb + addr_bw'(wr);
            wr <= wr + 8'd1;
          end
          if (drain_rd) begin
            inst[6] <= 1'b1;
            rd <= rd + 8'd1;
          end
          pend <= drain_rd;
        end
        FIN: state <= IDLE;
      endcase
    end
  end
`ifdef TILE_SEQ_PERF_EN
  logic stalled;
  assign stalled = ((state == W_FILL || state == X_FILL) && wr != fill_tgt && pend && l0_full) ||
                   (state == DRAIN && wr != na && rd < na && !ofifo_valid);
  always_ff @(posedge clk) begin
    if (reset || (state == IDLE && start && !bad_num)) stall_cnt <= '0;
    else if (stalled && stall_cnt != 16'hffff) stall_cnt <= stall_cnt + 16'd1;
  end
`endif
endmodule
